// File: rtl/station_adc_pkg.sv
// Shared constants and helpers for the station ADC emulator bank.
package station_adc_pkg;

   localparam int CLIP_CNT_W = 16;

   // The clear register sits at the all-ones host address.
   function automatic int adc_clr_addr(input int aw);
      return (1 << aw) - 1;
   endfunction

   function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v,
                                                        input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/adc_em_bank_if.sv
// Host configuration bus of the ADC emulator bank: offset/clear writes and clip-counter reads.
interface adc_em_bank_if #(
   parameter int aw = 5
);
   logic          wr_en;
   logic [aw-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic [aw-1:0] rd_addr;
   logic [15:0]   rd_data;

   modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
   modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/adc_chan_sat.sv
// One emulated ADC channel: offset register, two-stage offset/dither/saturate datapath, clip counter.
module adc_chan_sat
   import station_adc_pkg::*;
#(
   parameter int in_w  = 18,
   parameter int out_w = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     strobe_i,
   input  logic                     vld1_i,
   input  logic                     vld2_i,
   input  logic                     off_we_i,
   input  logic [15:0]              off_data_i,
   input  logic                     clr_i,
   input  logic [in_w-out_w-1:0]    dith_i,
   input  logic signed [in_w-1:0]   in_i,
   output logic [out_w-1:0]         code_o,
   output logic                     clip_o,
   output logic [CLIP_CNT_W-1:0]    cnt_o
);
   localparam int d     = in_w - out_w;
   localparam int acc_w = in_w + 2;

   logic signed [15:0]      off_q;
   logic signed [acc_w-1:0] acc_q, acc_d;
   logic signed [31:0]      q32;
   logic [out_w-1:0]        code_q, code_d;
   logic                    clip_q, clip_d;
   logic [CLIP_CNT_W-1:0]   cnt_q, cnt_d;

   assign acc_d = acc_w'(in_i) + (acc_w'(off_q) <<< d) + signed'(acc_w'(dith_i));

   assign q32    = 32'(acc_q >>> d);
   assign clip_d = (sat_to_width(q32, out_w) != q32);
   assign code_d = out_w'(sat_to_width(q32, out_w));

   // A clear in the same cycle as a clipping sample leaves the counter at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (vld2_i && clip_q && (cnt_q != '1))
         cnt_d = cnt_q + CLIP_CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         off_q  <= '0;
         acc_q  <= '0;
         code_q <= '0;
         clip_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (off_we_i) off_q <= off_data_i;
         if (strobe_i) acc_q <= acc_d;
         if (vld1_i) begin
            code_q <= code_d;
            clip_q <= clip_d;
         end
         cnt_q <= cnt_d;
      end
   end

   assign code_o = code_q;
   assign clip_o = clip_q;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/adc_em_bank.sv
// Multi-channel ADC emulator: n_chan offset/dither/saturate channels with host offsets and clip counters.
// Dither from rnd is enabled by defining ADC_EM_BANK_DITHER_EN; otherwise the ADC truncates deterministically.
module adc_em_bank
   import station_adc_pkg::*;
#(
   parameter int n_chan = 3,
   parameter int in_w   = 18,
   parameter int out_w  = 16,
   parameter int aw     = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    strobe,
   input  logic [n_chan*in_w-1:0]  in_data,
   input  logic [31:0]             rnd,
   output logic [n_chan*out_w-1:0] adc,
   output logic                    adc_valid,
   output logic [n_chan-1:0]       clip,
   adc_em_bank_if.slave            host
);
   localparam int d = in_w - out_w;
   localparam logic [aw-1:0] clr_addr = aw'(adc_clr_addr(aw));

   logic                  vld1_q, vld2_q;
   logic [15:0]           rd_q, rd_d;
   logic                  clr_hit;
   logic                  unused_rnd;
   logic [CLIP_CNT_W-1:0] cnt [n_chan];

   assign clr_hit    = host.wr_en && (host.wr_addr == clr_addr);
   assign unused_rnd = ^rnd;

   for (genvar k = 0; k < n_chan; k++) begin : g_chan
      logic [d-1:0] dith;
`ifdef ADC_EM_BANK_DITHER_EN
      assign dith = rnd[k*d +: d];
`else
      assign dith = '0;
`endif
      adc_chan_sat #(.in_w(in_w), .out_w(out_w)) u_chan (
         .clk        (clk),
         .rst        (rst),
         .strobe_i   (strobe),
         .vld1_i     (vld1_q),
         .vld2_i     (vld2_q),
         .off_we_i   (host.wr_en && (host.wr_addr == aw'(k))),
         .off_data_i (host.wr_data),
         .clr_i      (clr_hit && host.wr_data[k]),
         .dith_i     (dith),
         .in_i       (in_data[k*in_w +: in_w]),
         .code_o     (adc[k*out_w +: out_w]),
         .clip_o     (clip[k]),
         .cnt_o      (cnt[k])
      );
   end

   always_comb begin
      rd_d = '0;
      for (int k = 0; k < n_chan; k++)
         if (host.rd_addr == aw'(k)) rd_d = cnt[k];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld1_q <= 1'b0;
         vld2_q <= 1'b0;
         rd_q   <= '0;
      end else begin
         vld1_q <= strobe;
         vld2_q <= vld1_q;
         rd_q   <= rd_d;
      end
   end

   assign adc_valid    = vld2_q;
   assign host.rd_data = rd_q;

endmodule

// File: tb/tb_adc_em_bank.sv
// Bench for adc_em_bank: directed plan items plus randomized traffic against a cycle-level reference model.
module tb_adc_em_bank;
   localparam int N  = 3;
   localparam int IW = 18;
   localparam int OW = 16;
   localparam int AW = 5;
   localparam int D  = IW - OW;

   logic            clk = 1'b0;
   logic            rst;
   logic            strobe;
   logic [N*IW-1:0] in_data;
   logic [31:0]     rnd;
   logic [N*OW-1:0] adc;
   logic            adc_valid;
   logic [N-1:0]    clip;

   adc_em_bank_if #(.aw(AW)) bus ();

   adc_em_bank #(.n_chan(N), .in_w(IW), .out_w(OW), .aw(AW)) dut (
      .clk(clk), .rst(rst), .strobe(strobe), .in_data(in_data), .rnd(rnd),
      .adc(adc), .adc_valid(adc_valid), .clip(clip), .host(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // stimulus to apply at the next step
   logic          n_stb;
   logic [IW-1:0] n_in [N];
   logic [31:0]   n_rnd;
   logic          n_we;
   logic [AW-1:0] n_wa;
   logic [15:0]   n_wd;
   logic [AW-1:0] n_ra;
   logic [AW-1:0] ones_addr;

   // reference model state
   int m_off [N];
   int m_cnt [N];
   int cnt_vis [N];
   int prev_ra;
   bit pv [4];
   int pcode [4][N];
   bit pclip [4][N];
   int m_adc [N];
   bit m_clip [N];
   int t = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
   endtask

   function automatic int sx(input logic [31:0] v, input int w);
      int r;
      r = int'(v << (32 - w));
      return r >>> (32 - w);
   endfunction

   // ADC transfer: floor((x + off*2^D + dither) / 2^D), clamped to the signed OW range
   function automatic void conv(input int x, input int off, input int dith,
                                output int code, output bit cl);
      int s, q, hi, lo;
      s  = x + off * (1 << D) + dith;
      q  = (s >= 0) ? s / (1 << D) : -((-s + (1 << D) - 1) / (1 << D));
      hi = (1 << (OW - 1)) - 1;
      lo = -(1 << (OW - 1));
      cl = 1'b1;
      if (q > hi)      code = hi;
      else if (q < lo) code = lo;
      else begin
         code = q;
         cl   = 1'b0;
      end
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_off[k] = 0; m_cnt[k] = 0; cnt_vis[k] = 0; m_adc[k] = 0; m_clip[k] = 1'b0;
      end
      for (int s = 0; s < 4; s++) pv[s] = 1'b0;
      prev_ra = int'(n_ra);
   endtask

   task automatic step();
      int sl, ns, e_rd, code, dith, idx;
      bit cl;
      logic [15:0] c16;
      @(negedge clk);
      t++;
      sl = t % 4;
      if (pv[sl])
         for (int k = 0; k < N; k++) begin
            m_adc[k]  = pcode[sl][k];
            m_clip[k] = pclip[sl][k];
         end
      chk("adc_valid", 32'(adc_valid), 32'(pv[sl]));
      for (int k = 0; k < N; k++) begin
         c16 = 16'(m_adc[k]);
         chk($sformatf("adc%0d", k), 32'(adc[k*OW +: OW]), 32'(c16));
         chk($sformatf("clip%0d", k), 32'(clip[k]), 32'(m_clip[k]));
      end
      e_rd = (prev_ra < N) ? cnt_vis[prev_ra] : 0;
      chk("rd_data", 32'(bus.rd_data), 32'(e_rd));

      strobe = n_stb;
      for (int k = 0; k < N; k++) in_data[k*IW +: IW] = n_in[k];
      rnd         = n_rnd;
      bus.wr_en   = n_we;
      bus.wr_addr = n_wa;
      bus.wr_data = n_wd;
      bus.rd_addr = n_ra;

      for (int k = 0; k < N; k++) begin
         cnt_vis[k] = m_cnt[k];
         if (n_we && (n_wa == ones_addr) && n_wd[k])
            m_cnt[k] = 0;
         else if (pv[sl] && m_clip[k] && (m_cnt[k] < 65535))
            m_cnt[k] = m_cnt[k] + 1;
      end
      pv[sl] = 1'b0;
      if (n_stb) begin
         ns = (t + 2) % 4;
         for (int k = 0; k < N; k++) begin
`ifdef ADC_EM_BANK_DITHER_EN
            dith = int'((n_rnd >> (D * k)) & ((32'd1 << D) - 32'd1));
`else
            dith = 0;
`endif
            conv(sx(32'(n_in[k]), IW), m_off[k], dith, code, cl);
            pcode[ns][k] = code;
            pclip[ns][k] = cl;
         end
         pv[ns] = 1'b1;
      end
      idx = int'(n_wa);
      if (n_we && (idx < N)) m_off[idx] = sx(32'(n_wd), 16);
      prev_ra = int'(n_ra);
   endtask

   task automatic pipe(input int n);
      n_stb = 1'b0; n_we = 1'b0;
      repeat (n) step();
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [15:0] v);
      n_stb = 1'b0; n_we = 1'b1; n_wa = a; n_wd = v;
      step();
      n_we = 1'b0;
   endtask

   task automatic samp(input logic [IW-1:0] i0, input logic [IW-1:0] i1, input logic [IW-1:0] i2);
      n_in[0] = i0; n_in[1] = i1; n_in[2] = i2;
      n_stb = 1'b1;
      step();
      n_stb = 1'b0;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1; strobe = 1'b0; bus.wr_en = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_valid", 32'(adc_valid), 32'd0);
      chk("rst_adc", 32'(adc[31:0]), 32'd0);
      chk("rst_adc2", 32'(adc[47:32]), 32'd0);
      chk("rst_clip", 32'(clip), 32'd0);
      chk("rst_rd", 32'(bus.rd_data), 32'd0);
      rst = 1'b0;
   endtask

   initial begin
      ones_addr = '1;
      rst = 1'b1; strobe = 1'b0; in_data = '0; rnd = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
      n_stb = 1'b0; n_rnd = '0; n_we = 1'b0; n_wa = '0; n_wd = '0; n_ra = '0;
      for (int k = 0; k < N; k++) n_in[k] = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_valid", 32'(adc_valid), 32'd0);
      chk("reset_adc", 32'(adc[31:0]), 32'd0);
      chk("reset_clip", 32'(clip), 32'd0);
      chk("reset_rd", 32'(bus.rd_data), 32'd0);
      rst = 1'b0;
      pipe(2);

      // basic conversion, one valid pulse
      samp(18'h00400, 18'h00400, 18'h00400);
      pipe(2);
      chk("tp_400_adc", 32'(adc[15:0]), 32'h0100);
      chk("tp_400_valid", 32'(adc_valid), 32'd1);
      pipe(1);
      chk("tp_400_pulse", 32'(adc_valid), 32'd0);

      // positive and negative saturation
      wr(5'd0, 16'd5);
      samp(18'h1FFFF, 18'h0, 18'h0);
      pipe(2);
      chk("tp_pos_sat", 32'(adc[15:0]), 32'h7FFF);
      chk("tp_pos_clip", 32'(clip[0]), 32'd1);
      pipe(2);
      chk("tp_cnt_1", 32'(bus.rd_data), 32'd1);
      wr(5'd0, 16'hFFFB);
      samp(18'h20000, 18'h0, 18'h0);
      pipe(2);
      chk("tp_neg_sat", 32'(adc[15:0]), 32'h8000);
      chk("tp_neg_clip", 32'(clip[0]), 32'd1);
      pipe(2);
      chk("tp_cnt_2", 32'(bus.rd_data), 32'd2);

      // full-scale inputs without offset land exactly on the rails without clipping
      wr(5'd0, 16'h0);
      samp(18'h1FFFF, 18'h20000, 18'h0);
      pipe(2);
      chk("tp_edge_hi", 32'(adc[15:0]), 32'h7FFF);
      chk("tp_edge_lo", 32'(adc[31:16]), 32'h8000);
      chk("tp_edge_clip", 32'(clip), 32'd0);

      // per-channel offset
      wr(5'd2, 16'hFFFD);
      samp(18'h0, 18'h0, 18'h0);
      pipe(2);
      chk("tp_off_ch2", 32'(adc[47:32]), 32'hFFFD);
      chk("tp_off_ch01", 32'(adc[31:0]), 32'h0);

      // counter saturation and clear-wins
      wr(5'd1, 16'd100);
      n_ra = 5'd1;
      n_in[0] = '0; n_in[1] = 18'h1FFFF; n_in[2] = '0;
      n_stb = 1'b1;
      repeat (70000) step();
      chk("tp_cnt_sat", 32'(bus.rd_data), 32'hFFFF);
      n_stb = 1'b0;
      step();
      n_we = 1'b1; n_wa = ones_addr; n_wd = 16'h0002;
      step();
      n_we = 1'b0;
      pipe(3);
      chk("tp_clr_ch1", 32'(bus.rd_data), 32'd0);
      n_ra = 5'd0;
      pipe(2);
      chk("tp_ch0_kept", 32'(bus.rd_data), 32'd2);

      // reset with a sample in flight
      samp(18'h00400, 18'h00400, 18'h00400);
      reset_pulse();
      samp(18'h0, 18'h0, 18'h0);
      pipe(2);
      chk("tp_rst_valid", 32'(adc_valid), 32'd1);
      chk("tp_rst_off", 32'(adc[47:0]), 32'd0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         n_stb = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < N; k++)
            n_in[k] = ($urandom_range(0, 3) == 0) ? IW'($urandom)
                                                  : IW'($urandom_range(0, 4095)) - IW'(2048);
         n_rnd = $urandom;
         n_we  = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 4))
            0: n_wa = 5'd0;
            1: n_wa = 5'd1;
            2: n_wa = 5'd2;
            3: n_wa = ones_addr;
            default: n_wa = 5'd7;
         endcase
         n_wd = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                            : 16'($urandom_range(0, 2000)) - 16'd1000;
         n_ra = AW'($urandom_range(0, 4));
         step();
      end
      pipe(4);

`ifdef ADC_EM_BANK_DITHER_EN
      wr(5'd0, 16'h0);
      n_rnd = 32'd3;
      samp(18'h00001, 18'h0, 18'h0);
      pipe(2);
      chk("tp_dith_3", 32'(adc[15:0]), 32'd1);
      n_rnd = 32'd0;
      samp(18'h00001, 18'h0, 18'h0);
      pipe(2);
      chk("tp_dith_0", 32'(adc[15:0]), 32'd0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
